mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: fixed-latency mult/div/madd/msub with mthi/mtlo writes.
// Results are computed from operands latched at start and committed on the final busy edge.
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] MULT_CNT = 8'(MULT_LAT);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_LAT);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
    logic             load;

    // Datapath on latched operands; op[0]=0 selects the signed variant.
    logic               signed_q, is_div_q, a_neg, b_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo, result;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
    logic               result_we;

    always_comb begin
        signed_q = ~op_q[0];
        is_div_q = (op_q[2:1] == 2'b01);
        a_ext    = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext    = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod     = a_ext * b_ext;
        hilo     = {hi_q, lo_q};

        // Magnitude division; most-negative / -1 wraps back to most-negative with rem 0.
        a_neg = signed_q & a_q[WIDTH-1];
        b_neg = signed_q & b_q[WIDTH-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;

        case (op_q)
            3'd0, 3'd1: result = prod;
            3'd2, 3'd3: result = {rem, quo};
            3'd4, 3'd5: result = hilo + prod;
            default:    result = hilo - prod;
        endcase
        result_we = !(is_div_q && (b_q == '0));
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = (op[2:1] == 2'b01) ? DIV_CNT : MULT_CNT;
                    state_d = BUSY;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                    if (result_we) {hi_d, lo_d} = result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand registers carry no reset; they are only read while BUSY.
    always_ff @(posedge clk) begin
        if (load) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    assign busy      = (state_q == BUSY);
    assign stall_req = start | busy;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand-written corner sequences,
// with expected HI/LO results queued at start and compared when busy drops.
module tb_mult_div_unit;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [2:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, stall_req;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [W-1:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[12];

    mult_div_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic set_hilo(input logic [W-1:0] hv, input logic [W-1:0] lv);
        hi_we = 1'b1; wdata = hv; tick; hi_we = 1'b0;
        lo_we = 1'b1; wdata = lv; tick; lo_we = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat, input int n_init);
        int n;
        logic [2*W-1:0] expv;
        n = n_init;
        while (busy && n < 300) begin
            n++;
            tick;
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        expv = exp_q.pop_front();
        check({name, " hilo"}, {hi, lo}, expv);
    endtask

    task automatic run_op(input string name, input logic [2:0] o,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_q.push_back({eh, el});
        op = o; a = av; b = bv; start = 1'b1;
        tick;
        start = 1'b0;
        // Scramble inputs while busy; latched operands must be used.
        a = ~av; b = bv + 32'd1; op = ~o;
        wait_done(name, (o == 3'd2 || o == 3'd3) ? DL : ML, 0);
    endtask

    initial begin
        vecs[0]  = '{"multu max*2",  3'd1, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0,        32'h00000001, 32'hFFFFFFFE};
        vecs[1]  = '{"div -7/2",     3'd2, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[2]  = '{"mult -3*5",    3'd0, 32'hFFFFFFFD, 32'd5,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[3]  = '{"divu 100/7",   3'd3, 32'd100,      32'd7,        32'h0, 32'h0,        32'h00000002, 32'h0000000E};
        vecs[4]  = '{"div 7/-2",     3'd2, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,        32'h00000001, 32'hFFFFFFFD};
        vecs[5]  = '{"madd carry",   3'd4, 32'd1,        32'd1,        32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[6]  = '{"msub wrap",    3'd6, 32'd1,        32'd1,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7]  = '{"maddu max",    3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd5,        32'hFFFFFFFE, 32'h00000006};
        vecs[8]  = '{"msubu 10-6",   3'd7, 32'd2,        32'd3,        32'h0, 32'd10,       32'h00000000, 32'h00000004};
        vecs[9]  = '{"divu by zero", 3'd3, 32'd99,       32'd0,        32'h0, 32'h1234,     32'h00000000, 32'h00001234};
        vecs[10] = '{"div overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h00000000, 32'h80000000};
        vecs[11] = '{"madd -2*3",    3'd4, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        tick; tick;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);

        // Combinational stall_req follows start under reset; start itself is ignored.
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3; hi_we = 1'b1; wdata = 32'h77;
        #1;
        check("stall_req in reset", 64'(stall_req), 64'd1);
        tick;
        check("start under reset busy", 64'(busy), 64'd0);
        check("writes under reset hilo", {hi, lo}, 64'd0);
        start = 1'b0; hi_we = 1'b0; reset = 1'b0;
        tick;

        // mthi and mtlo together.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A5A5A;
        tick;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi+mtlo", {hi, lo}, 64'h5A5A5A5A_5A5A5A5A);

        for (int i = 0; i < 12; i++) begin
            set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            check({vecs[i].name, " preload"}, {hi, lo}, {vecs[i].pre_hi, vecs[i].pre_lo});
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Start wins over simultaneous mthi in IDLE.
        set_hilo(32'h1111, 32'h2222);
        exp_q.push_back({32'h0, 32'd12});
        op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1; hi_we = 1'b1; wdata = 32'hFFFF;
        #1;
        check("stall_req on start", 64'(stall_req), 64'd1);
        tick;
        start = 1'b0; hi_we = 1'b0;
        check("start beats mthi", 64'(hi), 64'h1111);
        wait_done("start+mthi mult", ML, 0);

        // Second start and mthi at busy cycle 2 are ignored.
        set_hilo(32'h0, 32'h0);
        exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
        op = 3'd1; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
        tick;
        start = 1'b0;
        check("busy cycle 1", 64'(busy), 64'd1);
        tick;
        check("busy cycle 2", 64'(busy), 64'd1);
        start = 1'b1; op = 3'd3; a = 32'd5; b = 32'd1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
        tick;
        start = 1'b0; hi_we = 1'b0;
        check("mthi in busy ignored", 64'(hi), 64'd0);
        wait_done("busy ignore multu", ML, 2);
        tick;
        check("no queued start", 64'(busy), 64'd0);

        // Reset at busy cycle 3 of a div aborts it.
        set_hilo(32'hAAAA, 32'hBBBB);
        op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        check("div busy before reset", 64'(busy), 64'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        tick;
        check("abort stays idle", 64'(busy), 64'd0);
        run_op("multu after abort", 3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
